// File: rtl/mpa_debug_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpa_debug_ctrl_pkg
// Description : Shared definitions for the MPA back-door debug controller:
//               controller state encoding, target select codes and default
//               widths used by the controller and its address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package mpa_debug_ctrl_pkg;

    // Default widths
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_NUM_MEM       = 2;
    localparam int DEF_SEL_WIDTH     = 2;
    localparam int DEF_LEN_WIDTH     = 4;

    // Target select codes (0 means "no target" and is always illegal)
    localparam int SEL_NONE = 0;
    localparam int SEL_IM   = 1;
    localparam int SEL_DM   = 2;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HALT     = 3'd1,
        ST_WR       = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_OUT   = 3'd5,
        ST_RESP     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mpa_debug_ctrl_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mpa_debug_ctrl_addr_gen
// Description : Burst address generator. Holds the current word address
//               (wrapping modulo 2^ADDRESS_WIDTH), the latched burst length
//               and the beat counter, and flags the last beat of a burst.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_load           - capture i_start_addr / i_len, clear beats
//               i_step           - advance address and beat counter by one
//               i_start_addr     - burst start word address
//               i_len            - burst length minus one
//               o_addr           - current word address
//               o_last           - current beat is the final beat
// Revision    : 1.0 - initial release
// ============================================================================
module mpa_debug_ctrl_addr_gen #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_step,
    input  logic [ADDRESS_WIDTH-1:0] i_start_addr,
    input  logic [LEN_WIDTH-1:0]     i_len,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    output logic                     o_last
);

    localparam logic [ADDRESS_WIDTH-1:0] C_ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]     C_BEAT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [LEN_WIDTH-1:0]     beat_q, beat_d;

    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        beat_d = beat_q;
        if (i_load) begin
            addr_d = i_start_addr;
            len_d  = i_len;
            beat_d = '0;
        end else if (i_step) begin
            // Natural overflow gives the required wrap-around
            addr_d = addr_q + C_ADDR_ONE;
            beat_d = beat_q + C_BEAT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            addr_q <= addr_d;
            len_q  <= len_d;
            beat_q <= beat_d;
        end
    end

    assign o_addr = addr_q;
    assign o_last = (beat_q == len_q);

endmodule
`default_nettype wire

// File: rtl/mpa_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mpa_debug_ctrl
// Description : Back-door debug controller. Accepts burst read/write
//               commands, halts the core through a request/acknowledge
//               handshake, performs word-addressed auto-incrementing
//               transfers to one of NUM_MEM memories and returns a one-cycle
//               response.
// Ports       : CLK, HW_RST                     - clock, sync active-high reset
//               cmd_*                           - command channel
//               wdata_valid/ready, wdata        - write-beat channel
//               rdata_valid/ready, rdata        - read-beat channel
//               resp_valid, resp_err            - completion pulse / error
//               core_halt_req, core_halted      - core halt handshake
//               mem_addr, mem_wdata             - shared memory bus
//               mem_we, mem_re                  - one-hot strobes (bit i = sel i+1)
//               mem_rdata                       - concatenated memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mpa_debug_ctrl
    import mpa_debug_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_MEM       = DEF_NUM_MEM,
    parameter int SEL_WIDTH     = DEF_SEL_WIDTH,
    parameter int LEN_WIDTH     = DEF_LEN_WIDTH
) (
    input  logic                          CLK,
    input  logic                          HW_RST,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [SEL_WIDTH-1:0]          cmd_sel,
    input  logic [ADDRESS_WIDTH-1:0]      cmd_addr,
    input  logic [LEN_WIDTH-1:0]          cmd_len,
    input  logic                          cmd_keep_halt,
    input  logic                          wdata_valid,
    output logic                          wdata_ready,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic                          rdata_valid,
    input  logic                          rdata_ready,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          resp_valid,
    output logic                          resp_err,
    output logic                          core_halt_req,
    input  logic                          core_halted,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [NUM_MEM-1:0]            mem_we,
    output logic [NUM_MEM-1:0]            mem_re,
    input  logic [NUM_MEM*DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [31:0] C_NUM_MEM = 32'(NUM_MEM);

    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic                     keep_q, keep_d;
    logic                     err_q, err_d;
    logic                     halt_q, halt_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

    logic                     w_cmd_fire;
    logic                     w_cmd_sel_legal;
    logic                     w_ag_load;
    logic                     w_ag_step;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic                     w_last;
    logic [NUM_MEM-1:0]       w_sel_oh;
    logic [DATA_WIDTH-1:0]    w_rd_slice;

    // ------------------------------------------------------------------
    // Address / beat generator
    // ------------------------------------------------------------------
    mpa_debug_ctrl_addr_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH)
    ) u_addr_gen (
        .clk          (CLK),
        .rst          (HW_RST),
        .i_load       (w_ag_load),
        .i_step       (w_ag_step),
        .i_start_addr (cmd_addr),
        .i_len        (cmd_len),
        .o_addr       (w_addr),
        .o_last       (w_last)
    );

    // ------------------------------------------------------------------
    // Target decode: one-hot of the latched select, read-data slice mux
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_sel_dec
        assign w_sel_oh[gi] = (32'(sel_q) == 32'(gi + 1));
    end

    always_comb begin
        w_rd_slice = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (w_sel_oh[i]) begin
                w_rd_slice = w_rd_slice | mem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_cmd_sel_legal = (cmd_sel != '0) && (32'(cmd_sel) <= C_NUM_MEM);
    assign w_cmd_fire      = cmd_valid && cmd_ready;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        sel_d     = sel_q;
        keep_d    = keep_q;
        err_d     = err_q;
        halt_d    = halt_q;
        rdata_d   = rdata_q;
        w_ag_load = 1'b0;
        w_ag_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    write_d   = cmd_write;
                    sel_d     = cmd_sel;
                    keep_d    = cmd_keep_halt;
                    w_ag_load = 1'b1;
                    if (w_cmd_sel_legal) begin
                        err_d   = 1'b0;
                        halt_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        // Rejected without touching the core or memories;
                        // the existing halt state is left as it is.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_HALT: begin
                if (core_halted) begin
                    state_d = write_q ? ST_WR : ST_RD_ISSUE;
                end
            end
            ST_WR: begin
                if (wdata_valid) begin
                    w_ag_step = 1'b1;
                    if (w_last) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                rdata_d = w_rd_slice;
                state_d = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (rdata_ready) begin
                    w_ag_step = 1'b1;
                    state_d   = w_last ? ST_RESP : ST_RD_ISSUE;
                end
            end
            ST_RESP: begin
                if (!err_q && !keep_q) begin
                    halt_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (HW_RST) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            sel_q   <= '0;
            keep_q  <= 1'b0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            keep_q  <= keep_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Ready signals and the write path are combinational and are
    // forced low while reset is held so nothing is strobed in that cycle.
    // ------------------------------------------------------------------
    assign cmd_ready     = (state_q == ST_IDLE) && !HW_RST;
    assign wdata_ready   = (state_q == ST_WR) && !HW_RST;
    assign mem_we        = (wdata_ready && wdata_valid) ? w_sel_oh : '0;
    assign mem_wdata     = wdata_ready ? wdata : '0;
    assign mem_re        = (state_q == ST_RD_ISSUE) ? w_sel_oh : '0;
    assign mem_addr      = w_addr;
    assign rdata_valid   = (state_q == ST_RD_OUT);
    assign rdata         = rdata_q;
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_err      = (state_q == ST_RESP) && err_q;
    assign core_halt_req = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_mpa_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpa_debug_ctrl
// Description : Self-checking bench for mpa_debug_ctrl with an 8-bit
//               address bus (exercises wrap-around), a memory/core
//               environment, and a transaction-level scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpa_debug_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NM = 2;
    localparam int SW = 2;
    localparam int LW = 4;

    logic           CLK = 1'b0;
    logic           HW_RST = 1'b1;
    logic           cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_keep_halt = 1'b0;
    logic [SW-1:0]  cmd_sel = '0;
    logic [AW-1:0]  cmd_addr = '0;
    logic [LW-1:0]  cmd_len = '0;
    logic           wdata_valid = 1'b0, wdata_ready;
    logic [DW-1:0]  wdata = '0;
    logic           rdata_valid, rdata_ready = 1'b1;
    logic [DW-1:0]  rdata;
    logic           resp_valid, resp_err, core_halt_req;
    logic           core_halted = 1'b0;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [NM-1:0]  mem_we, mem_re;
    logic [NM*DW-1:0] mem_rdata = '0;

    always #5 CLK = ~CLK;

    mpa_debug_ctrl #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_MEM(NM), .SEL_WIDTH(SW), .LEN_WIDTH(LW)
    ) dut (
        .CLK(CLK), .HW_RST(HW_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_keep_halt(cmd_keep_halt),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .core_halt_req(core_halt_req), .core_halted(core_halted),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: memories and core ----------------
    logic [DW-1:0] env_mem [NM][256];
    logic [DW-1:0] ref_mem [NM][256];
    logic [NM-1:0] pend_re = '0;
    logic [AW-1:0] pend_addr = '0;
    int            halt_delay = 0;
    int            halt_cnt = 0;

    always @(posedge CLK) begin
        pend_re   = mem_re;
        pend_addr = mem_addr;
        for (int i = 0; i < NM; i++)
            if (mem_we[i]) env_mem[i][mem_addr] = mem_wdata;
    end

    // Read data is only meaningful in the cycle after mem_re; junk otherwise
    always @(negedge CLK) begin
        for (int i = 0; i < NM; i++)
            mem_rdata[i*DW +: DW] = pend_re[i] ? env_mem[i][pend_addr] : (32'hBAD0_0000 | i);
        if (!core_halt_req) begin
            core_halted = 1'b0;
            halt_cnt    = 0;
        end else if (halt_cnt >= halt_delay) begin
            core_halted = 1'b1;
        end else begin
            halt_cnt++;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    bit            exp_resp[$];
    bit            rd_out = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_rdata = '0;

    always @(negedge CLK) begin
        if (HW_RST) begin
            chk("rst_mem_we", mem_we, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_wdata_ready", wdata_ready, 0);
            rd_out     = 0;
            prev_stall = 0;
        end else begin
            if (mem_we != 0) begin
                chk("we_while_halted", {core_halt_req, core_halted}, 2'b11);
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", mem_we, 0);
                end else begin
                    wr_t e;
                    logic [NM-1:0] oh;
                    e  = exp_wr.pop_front();
                    oh = '0;
                    oh[e.sel-1] = 1'b1;
                    chk("wr_strobe", mem_we, oh);
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                end
            end
            if (mem_re != 0) begin
                chk("re_while_halted", {core_halt_req, core_halted}, 2'b11);
                chk("re_single_outstanding", rd_out, 0);
                rd_out = 1;
            end
            if (prev_stall)
                chk("rdata_stable", {rdata_valid, rdata}, {1'b1, prev_rdata});
            if (rdata_valid && rdata_ready) begin
                if (exp_rd.size() == 0) chk("unexpected_rdata", rdata_valid, 0);
                else chk("rd_data", rdata, exp_rd.pop_front());
                rd_out = 0;
            end
            prev_stall = rdata_valid && !rdata_ready;
            prev_rdata = rdata;
            if (resp_valid) begin
                if (exp_resp.size() == 0) chk("unexpected_resp", resp_valid, 0);
                else chk("resp_err", resp_err, exp_resp.pop_front());
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    // Entered and left at #1 after a rising edge.
    task automatic issue_cmd(input bit wr, input int sel, input int addr, input int len, input bit keep);
        int n;
        cmd_write = wr; cmd_sel = SW'(sel); cmd_addr = AW'(addr);
        cmd_len = LW'(len); cmd_keep_halt = keep; cmd_valid = 1'b1;
        n = 0;
        do begin @(posedge CLK); n++; end while (!cmd_ready && n < 50);
        chk("cmd_accept", cmd_ready, 1);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input int sel, input int addr, input int len, input bit keep,
                               input logic [DW-1:0] base, input int delay);
        int n;
        for (int k = 0; k <= len; k++) begin
            wr_t e;
            e.sel = sel; e.addr = AW'(addr + k); e.data = base + DW'(k);
            exp_wr.push_back(e);
            ref_mem[sel-1][e.addr] = e.data;
        end
        exp_resp.push_back(1'b0);
        halt_delay = delay;
        issue_cmd(1'b1, sel, addr, len, keep);
        wdata_valid = 1'b1; wdata = base;
        @(negedge CLK);
        chk("halt_req_in_halt", core_halt_req, 1);
        chk("no_wready_in_halt", wdata_ready, 0);
        for (int k = 0; k <= len; k++) begin
            n = 0;
            do begin @(posedge CLK); n++; end while (!wdata_ready && n < 50);
            chk("wbeat_accept", wdata_ready, 1);
            if (k > 0) chk("wbeat_back_to_back", n, 1);
            #1 wdata = base + DW'(k + 1);
        end
        wdata_valid = 1'b0;
        @(negedge CLK);
        chk("wr_resp_valid", {resp_valid, resp_err}, 2'b10);
        @(negedge CLK);
        chk("wr_halt_after_resp", core_halt_req, keep);
    endtask

    task automatic read_burst(input int sel, input int addr, input int len, input bit keep,
                              input bit stall_first, input bit fast_halt);
        int n;
        for (int k = 0; k <= len; k++) exp_rd.push_back(ref_mem[sel-1][AW'(addr + k)]);
        exp_resp.push_back(1'b0);
        rdata_ready = !stall_first;
        issue_cmd(1'b0, sel, addr, len, keep);
        if (fast_halt) begin
            logic [NM-1:0] oh;
            oh = '0; oh[sel-1] = 1'b1;
            @(negedge CLK);
            chk("fast_halt_req", core_halt_req, 1);
            @(negedge CLK);
            chk("fast_halt_re", mem_re, oh);
        end
        for (int k = 0; k <= len; k++) begin
            n = 0;
            while (!rdata_valid && n < 50) begin @(negedge CLK); n++; end
            chk("rbeat_valid", rdata_valid, 1);
            if (stall_first && k == 0) begin
                chk("first_read_word", rdata, 32'hDEADBEEF);
                repeat (3) @(posedge CLK);
                #1 rdata_ready = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("rd_resp_valid", {resp_valid, resp_err}, 2'b10);
        @(negedge CLK);
        chk("rd_halt_after_resp", core_halt_req, keep);
    endtask

    task automatic illegal_cmd(input int sel);
        exp_resp.push_back(1'b1);
        wdata_valid = 1'b1; wdata = 32'h5555_AAAA;
        issue_cmd(1'b1, sel, 8'h30, 2, 1'b0);
        @(negedge CLK);
        chk("illegal_resp", {resp_valid, resp_err}, 2'b11);
        chk("illegal_no_halt", core_halt_req, 0);
        chk("illegal_no_wready", wdata_ready, 0);
        @(negedge CLK);
        chk("illegal_idle_after", {cmd_ready, wdata_ready, core_halt_req, resp_valid}, 4'b1000);
        wdata_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < NM; i++)
            for (int a = 0; a < 256; a++) begin
                env_mem[i][a] = 32'h1000_0000 * (i + 1) + a;
                ref_mem[i][a] = 32'h1000_0000 * (i + 1) + a;
            end
        env_mem[1][8'h20] = 32'hDEADBEEF; ref_mem[1][8'h20] = 32'hDEADBEEF;
        env_mem[1][8'h21] = 32'hCAFEF00D; ref_mem[1][8'h21] = 32'hCAFEF00D;

        // Power-on reset
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_regs", {core_halt_req, resp_valid, resp_err, rdata_valid, mem_re, mem_we}, 0);
        chk("reset_addr_rdata", {mem_addr, rdata}, 0);
        @(posedge CLK); #1 HW_RST = 1'b0;
        @(negedge CLK);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // IM write, core acknowledges late
        write_burst(1, 8'h10, 3, 1'b0, 32'hA0, 3);

        // DM read with back-pressure on the first word
        read_burst(2, 8'h20, 1, 1'b0, 1'b1, 1'b0);

        // Illegal selects
        illegal_cmd(0);
        illegal_cmd(3);

        // Address wrap on the 8-bit bus, then read back across the wrap
        write_burst(2, 8'hFE, 3, 1'b0, 32'h11, 0);
        read_burst(2, 8'hFF, 1, 1'b0, 1'b0, 1'b0);

        // keep_halt: halt persists through IDLE, second command is fast
        write_burst(1, 8'h40, 0, 1'b1, 32'h5A, 1);
        repeat (3) begin
            @(negedge CLK);
            chk("keep_halt_idle", {cmd_ready, core_halt_req}, 2'b11);
        end
        #1;
        read_burst(1, 8'h40, 0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a write burst: only beat 0 lands
        begin
            wr_t e;
            e.sel = 1; e.addr = 8'h60; e.data = 32'hC0;
            exp_wr.push_back(e);
            ref_mem[0][8'h60] = 32'hC0;
        end
        halt_delay = 0;
        #1;
        issue_cmd(1'b1, 1, 8'h60, 3, 1'b0);
        wdata_valid = 1'b1; wdata = 32'hC0;
        begin
            int n;
            n = 0;
            do begin @(posedge CLK); n++; end while (!wdata_ready && n < 50);
            chk("rst_burst_beat0", wdata_ready, 1);
        end
        #1 wdata = 32'hC1; HW_RST = 1'b1;
        @(negedge CLK);
        chk("midrst_comb_low", {mem_we, wdata_ready, cmd_ready}, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("midrst_regs", {core_halt_req, resp_valid, rdata_valid, mem_re, mem_we}, 0);
        chk("midrst_addr_rdata", {mem_addr, rdata}, 0);
        @(posedge CLK); #1 HW_RST = 1'b0; wdata_valid = 1'b0;
        @(negedge CLK);
        chk("midrst_release", {cmd_ready, core_halt_req}, 2'b10);
        #1;
        @(posedge CLK); #1;
        // 0x60 holds beat 0, 0x61 must be untouched
        read_burst(1, 8'h60, 1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge CLK);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
